// File: rtl/fifo_if.sv
// fifo_if: handshake bundle for the single-clock FIFO.
// Optional FIFO_ERR_FLAGS_EN adds sticky overflow/underflow status.
interface fifo_if #(
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst_n
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  full;
  logic                  empty;
`ifdef FIFO_ERR_FLAGS_EN
  logic                  overflow;
  logic                  underflow;
`endif

  // FIFO side of the bundle.
  modport fifo (
    input  clk, rst_n, wr_en, wr_data, rd_en,
`ifdef FIFO_ERR_FLAGS_EN
    output overflow, underflow,
`endif
    output rd_data, full, empty
  );

  // Producer/consumer side of the bundle.
  modport master (
    input  clk, rst_n,
`ifdef FIFO_ERR_FLAGS_EN
    input  overflow, underflow,
`endif
    input  rd_data, full, empty,
    output wr_en, wr_data, rd_en
  );
endinterface

// File: rtl/fifo.sv
// fifo: single-clock synchronous FIFO, first-word-fall-through read port.
// Depth need not be a power of two; indices wrap by explicit compare.
// Optional macro FIFO_ERR_FLAGS_EN adds sticky overflow/underflow flags.
module fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 8
) (
  fifo_if.fifo bus
);
  localparam int IDX_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = IDX_W + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [IDX_W-1:0]      w_idx_q, w_idx_d;
  logic [IDX_W-1:0]      r_idx_q, r_idx_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  do_wr, do_rd;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == IDX_W'(FIFO_DEPTH - 1)) ? '0 : idx + IDX_W'(1);
  endfunction

  assign bus.full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign bus.empty   = (count_q == '0);
  assign do_wr       = bus.wr_en & ~bus.full;
  assign do_rd       = bus.rd_en & ~bus.empty;
  assign bus.rd_data = bus.empty ? '0 : mem[r_idx_q];

  // Next-state for indices and occupancy; simultaneous accept leaves count alone.
  always_comb begin
    w_idx_d = do_wr ? next_idx(w_idx_q) : w_idx_q;
    r_idx_d = do_rd ? next_idx(r_idx_q) : r_idx_q;
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: indices and occupancy, cleared asynchronously.
  always_ff @(posedge bus.clk or negedge bus.rst_n) begin
    if (!bus.rst_n) begin
      w_idx_q <= '0;
      r_idx_q <= '0;
      count_q <= '0;
    end else begin
      w_idx_q <= w_idx_d;
      r_idx_q <= r_idx_d;
      count_q <= count_d;
    end
  end

  // Storage is left unreset; stale entries are hidden because rd_data is gated by empty.
  always_ff @(posedge bus.clk) begin
    if (do_wr) begin
      mem[w_idx_q] <= bus.wr_data;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  // Sticky error flags, cleared only by reset.
  always_ff @(posedge bus.clk or negedge bus.rst_n) begin
    if (!bus.rst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en & bus.full)  overflow_q  <= 1'b1;
      if (bus.rd_en & bus.empty) underflow_q <= 1'b1;
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_fifo.sv
// tb_fifo: table vectors plus scenario sequences with a queue scoreboard.
module tb_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  logic [DW-1:0] sb[$];

  fifo_if #(.DATA_WIDTH(DW)) bus (.clk(clk), .rst_n(rst_n));

  fifo #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (.bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          wr;
    logic [DW-1:0] d;
    logic          rd;
    logic          e_empty;
    logic          e_full;
    logic [DW-1:0] e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, check popped head before the edge, check status after it.
  task automatic step(input logic wr, input logic [DW-1:0] d, input logic rd);
    bit was_full, was_empty;
    @(negedge clk);
    bus.wr_en   = wr;
    bus.wr_data = d;
    bus.rd_en   = rd;
    #1;
    was_full  = (sb.size() == DEPTH);
    was_empty = (sb.size() == 0);
    if (rd && !was_empty) chk("pop_data", bus.rd_data, sb.pop_front());
    if (wr && !was_full) sb.push_back(d);
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    chk("full", bus.full, (sb.size() == DEPTH));
    chk("empty", bus.empty, (sb.size() == 0));
    chk("head", bus.rd_data, (sb.size() == 0) ? '0 : sb[0]);
  endtask

  initial begin
    vec_t tbl[8];
    logic [DW-1:0] w;
    n_cmp = 0;
    n_fail = 0;
    bus.wr_en = 1'b0;
    bus.wr_data = '0;
    bus.rd_en = 1'b0;

    // Reset held 5 cycles, released at negedge
    rst_n = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_empty", bus.empty, 1'b1);
    chk("rst_full", bus.full, 1'b0);
    chk("rst_rdata", bus.rd_data, 8'h00);

    // Table vectors starting from empty: expected state after each edge
    tbl[0] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[2] = '{1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h5A};
    tbl[3] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h5A};
    tbl[4] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 8'h3C};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h77};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].wr, tbl[i].d, tbl[i].rd);
      chk($sformatf("vec%0d_empty", i), bus.empty, tbl[i].e_empty);
      chk($sformatf("vec%0d_full", i), bus.full, tbl[i].e_full);
      chk($sformatf("vec%0d_rdata", i), bus.rd_data, tbl[i].e_rdata);
    end

    // Empty blocking: 5 idle pops, then a single word
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h5A, 1'b0);
    chk("blk_head", bus.rd_data, 8'h5A);
    step(1'b0, 8'h00, 1'b1);
    chk("blk_empty", bus.empty, 1'b1);

    // Alternating push/pop of random words
    for (int i = 0; i < 16; i++) begin
      w = DW'($urandom_range(0, 255));
      step(1'b1, w, 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end
    chk("alt_empty", bus.empty, 1'b1);

    // Full boundary
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'hA0 + i), 1'b0);
    chk("fb_full", bus.full, 1'b1);
    chk("fb_empty", bus.empty, 1'b0);
    step(1'b1, 8'hA8, 1'b0);
    chk("fb_stall_full", bus.full, 1'b1);
    chk("fb_stall_head", bus.rd_data, 8'hA0);
    step(1'b0, 8'h00, 1'b1);
    chk("fb_drop_full", bus.full, 1'b0);
    step(1'b1, 8'hA8, 1'b0);
    chk("fb_refull", bus.full, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1);
    chk("fb_drain_empty", bus.empty, 1'b1);

    // Simultaneous ops with 3 stored
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'hB0 + i), 1'b0);
    step(1'b1, 8'hB3, 1'b1);
    chk("sim3_head", bus.rd_data, 8'hB1);
    // Fill to full, then simultaneous
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hC0 + i), 1'b0);
    chk("simf_pre_full", bus.full, 1'b1);
    step(1'b1, 8'hEE, 1'b1);
    chk("simf_full", bus.full, 1'b0);
    chk("simf_head", bus.rd_data, 8'hB2);
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
    chk("simf_drained", bus.empty, 1'b1);
    // Simultaneous on empty: write only, no bypass
    step(1'b1, 8'hD4, 1'b1);
    chk("sime_empty", bus.empty, 1'b0);
    chk("sime_head", bus.rd_data, 8'hD4);
    step(1'b0, 8'h00, 1'b1);

    // Async reset mid-stream with 5 stored
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'hE0 + i), 1'b0);
    chk("ar_pre_empty", bus.empty, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_empty", bus.empty, 1'b1);
    chk("ar_full", bus.full, 1'b0);
    chk("ar_rdata", bus.rd_data, 8'h00);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h11, 1'b0);
    chk("ar_after_head", bus.rd_data, 8'h11);
    step(1'b0, 8'h00, 1'b1);

`ifdef FIFO_ERR_FLAGS_EN
    chk("ovf_init", bus.overflow, 1'b0);
    chk("udf_init", bus.underflow, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_set", bus.underflow, 1'b1);
    chk("ovf_still0", bus.overflow, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h20 + i), 1'b0);
    chk("ovf_not_yet", bus.overflow, 1'b0);
    step(1'b1, 8'h99, 1'b0);
    chk("ovf_set", bus.overflow, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    chk("ovf_sticky", bus.overflow, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("ovf_rst", bus.overflow, 1'b0);
    chk("udf_rst", bus.underflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
